// File: rtl/mw_wb_pkg.sv
// Shared types and lane-slicing helpers for the MEM/WB bundle register.
package mw_wb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 5;

  // Occupancy of the main/skid pair: empty, main only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  // Bit offset of lane k inside a packed data bus.
  function automatic int data_slice(input int lane, input int data_w);
    return lane * data_w;
  endfunction

  // Bit offset of lane k inside a packed register-index bus.
  function automatic int reg_slice(input int lane, input int reg_w);
    return lane * reg_w;
  endfunction

endpackage

// File: rtl/wb_hazard_qual.sv
// Combinational write-enable qualification for a bundle: kill, zero-register
// and in-bundle write-after-write (the younger, higher-index lane wins).
module wb_hazard_qual
  import mw_wb_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic [LANES-1:0]       reg_write,
  input  logic [LANES-1:0]       kill_mask,
  input  logic [LANES*REG_W-1:0] write_reg,
  output logic [LANES-1:0]       reg_write_c,
  output logic [LANES-1:0]       waw_squash_c
);

  logic [LANES-1:0] live;

  // A lane is live if enabled, not killed and not targeting register 0.
  always_comb begin
    live = '0;
    for (int k = 0; k < LANES; k++) begin
      live[k] = reg_write[k] & ~kill_mask[k] &
                (write_reg[reg_slice(k, REG_W) +: REG_W] != '0);
    end
  end

  // An older live lane is squashed when any younger live lane hits the same register.
  always_comb begin
    waw_squash_c = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (live[i] && live[j] &&
            (write_reg[reg_slice(i, REG_W) +: REG_W] == write_reg[reg_slice(j, REG_W) +: REG_W])) begin
          waw_squash_c[i] = 1'b1;
        end
      end
    end
    reg_write_c = live & ~waw_squash_c;
  end

endmodule

// File: rtl/mw_wb_bundle_reg.sv
// MEM/WB pipeline register for a multi-lane bundle with a 2-entry skid buffer,
// flush, per-lane kill and write-back hazard qualification.
module mw_wb_bundle_reg
  import mw_wb_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  input  logic [LANES-1:0]        kill_mask,
  input  logic [LANES-1:0]        MemToReg,
  input  logic [LANES-1:0]        RegWrite,
  input  logic [LANES*DATA_W-1:0] mem_read_data,
  input  logic [LANES*DATA_W-1:0] alu_result,
  input  logic [LANES*REG_W-1:0]  write_reg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        MemToReg_out,
  output logic [LANES-1:0]        RegWrite_out,
  output logic [LANES*DATA_W-1:0] mem_read_data_out,
  output logic [LANES*DATA_W-1:0] alu_result_out,
  output logic [LANES*REG_W-1:0]  write_reg_out,
  output logic [LANES*DATA_W-1:0] wb_data_out,
  output logic [LANES-1:0]        waw_squash
);

  localparam int unsigned DW = LANES * DATA_W;
  localparam int unsigned RW = LANES * REG_W;

  skid_state_t state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        accept_c, consume_c;
  logic        ld_m_in_c, ld_m_s_c, ld_s_in_c;

  logic [LANES-1:0] qual_rw_c, qual_waw_c;

  logic [LANES-1:0] m_mtr_q, m_rw_q, m_waw_q;
  logic [DW-1:0]    m_mem_q, m_alu_q;
  logic [RW-1:0]    m_wr_q;

  logic [LANES-1:0] s_mtr_q, s_rw_q, s_waw_q;
  logic [DW-1:0]    s_mem_q, s_alu_q;
  logic [RW-1:0]    s_wr_q;

  wb_hazard_qual #(
    .LANES (LANES),
    .REG_W (REG_W)
  ) u_qual (
    .reg_write    (RegWrite),
    .kill_mask    (kill_mask),
    .write_reg    (write_reg),
    .reg_write_c  (qual_rw_c),
    .waw_squash_c (qual_waw_c)
  );

  // Occupancy and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next occupancy and load steering; flush overrides every transfer.
  always_comb begin
    state_d   = state_q;
    ld_m_in_c = 1'b0;
    ld_m_s_c  = 1'b0;
    ld_s_in_c = 1'b0;
    accept_c  = in_valid & in_ready_q & ~flush;
    consume_c = out_valid_q & out_ready;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            ld_m_in_c = 1'b1;
            state_d   = ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (consume_c) begin
            if (accept_c) ld_m_in_c = 1'b1;
            else          state_d   = ST_EMPTY;
          end else if (accept_c) begin
            ld_s_in_c = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so nothing new can arrive.
          if (consume_c) begin
            ld_m_s_c = 1'b1;
            state_d  = ST_MAIN;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // Main entry: load from input or skid; drop write enables when it empties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mtr_q <= '0;
      m_rw_q  <= '0;
      m_waw_q <= '0;
      m_mem_q <= '0;
      m_alu_q <= '0;
      m_wr_q  <= '0;
    end else if (ld_m_in_c) begin
      m_mtr_q <= MemToReg;
      m_rw_q  <= qual_rw_c;
      m_waw_q <= qual_waw_c;
      m_mem_q <= mem_read_data;
      m_alu_q <= alu_result;
      m_wr_q  <= write_reg;
    end else if (ld_m_s_c) begin
      m_mtr_q <= s_mtr_q;
      m_rw_q  <= s_rw_q;
      m_waw_q <= s_waw_q;
      m_mem_q <= s_mem_q;
      m_alu_q <= s_alu_q;
      m_wr_q  <= s_wr_q;
    end else if (!out_valid_d) begin
      m_rw_q  <= '0;
      m_waw_q <= '0;
    end
  end

  // Skid entry: captures a bundle accepted while main is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_mtr_q <= '0;
      s_rw_q  <= '0;
      s_waw_q <= '0;
      s_mem_q <= '0;
      s_alu_q <= '0;
      s_wr_q  <= '0;
    end else if (ld_s_in_c) begin
      s_mtr_q <= MemToReg;
      s_rw_q  <= qual_rw_c;
      s_waw_q <= qual_waw_c;
      s_mem_q <= mem_read_data;
      s_alu_q <= alu_result;
      s_wr_q  <= write_reg;
    end
  end

  // Per-lane write-back data select from the main entry.
  always_comb begin
    wb_data_out = '0;
    for (int k = 0; k < LANES; k++) begin
      wb_data_out[data_slice(k, DATA_W) +: DATA_W] =
        m_mtr_q[k] ? m_mem_q[data_slice(k, DATA_W) +: DATA_W]
                   : m_alu_q[data_slice(k, DATA_W) +: DATA_W];
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign MemToReg_out      = m_mtr_q;
  assign RegWrite_out      = m_rw_q;
  assign waw_squash        = m_waw_q;
  assign mem_read_data_out = m_mem_q;
  assign alu_result_out    = m_alu_q;
  assign write_reg_out     = m_wr_q;

endmodule

// File: tb/tb_mw_wb_bundle_reg.sv
// Bench for mw_wb_bundle_reg: directed scenarios with literal expectations plus
// a randomized run against a queue-based model of the register.
module tb_mw_wb_bundle_reg;

  localparam int L  = 2;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [L-1:0]  kill_mask = '0;
  logic [L-1:0]  MemToReg = '0;
  logic [L-1:0]  RegWrite = '0;
  logic [L*DW-1:0] mem_read_data = '0;
  logic [L*DW-1:0] alu_result = '0;
  logic [L*RW-1:0] write_reg = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [L-1:0]  MemToReg_out;
  logic [L-1:0]  RegWrite_out;
  logic [L*DW-1:0] mem_read_data_out;
  logic [L*DW-1:0] alu_result_out;
  logic [L*RW-1:0] write_reg_out;
  logic [L*DW-1:0] wb_data_out;
  logic [L-1:0]  waw_squash;

  int n_cmp = 0;
  int n_bad = 0;

  mw_wb_bundle_reg #(.LANES(L), .DATA_W(DW), .REG_W(RW)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .flush             (flush),
    .kill_mask         (kill_mask),
    .MemToReg          (MemToReg),
    .RegWrite          (RegWrite),
    .mem_read_data     (mem_read_data),
    .alu_result        (alu_result),
    .write_reg         (write_reg),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .MemToReg_out      (MemToReg_out),
    .RegWrite_out      (RegWrite_out),
    .mem_read_data_out (mem_read_data_out),
    .alu_result_out    (alu_result_out),
    .write_reg_out     (write_reg_out),
    .wb_data_out       (wb_data_out),
    .waw_squash        (waw_squash)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [L-1:0]    mtr;
    logic [L-1:0]    rw;
    logic [L-1:0]    waw;
    logic [L*DW-1:0] mem;
    logic [L*DW-1:0] alu;
    logic [L*RW-1:0] wr;
  } bundle_t;

  bundle_t q[$];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Expected stored bundle: walk from the youngest lane, first claim of a register wins.
  function automatic bundle_t mk_bundle();
    bundle_t b;
    bit claimed [32];
    logic [RW-1:0] r;
    for (int i = 0; i < 32; i++) claimed[i] = 1'b0;
    b.mtr = MemToReg;
    b.mem = mem_read_data;
    b.alu = alu_result;
    b.wr  = write_reg;
    b.rw  = '0;
    b.waw = '0;
    for (int k = L - 1; k >= 0; k--) begin
      r = write_reg[k*RW +: RW];
      if (RegWrite[k] && !kill_mask[k] && r != 0) begin
        if (claimed[r]) b.waw[k] = 1'b1;
        else begin
          b.rw[k] = 1'b1;
          claimed[r] = 1'b1;
        end
      end
    end
    return b;
  endfunction

  function automatic logic [63:0] exp_wb(input bundle_t b);
    logic [L*DW-1:0] w;
    for (int k = 0; k < L; k++)
      w[k*DW +: DW] = b.mtr[k] ? b.mem[k*DW +: DW] : b.alu[k*DW +: DW];
    return 64'(w);
  endfunction

  // Model: a FIFO of at most two bundles; accept only while fewer than two are held.
  always @(posedge clk) begin : model
    bit acc;
    if (!reset || flush) q.delete();
    else begin
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back(mk_bundle());
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin : compare
    bundle_t h;
    if (!reset) begin
      cmp("rst_out_valid", 64'(out_valid), 64'd0);
      cmp("rst_regwrite", 64'(RegWrite_out), 64'd0);
      cmp("rst_wb_data", 64'(wb_data_out), 64'd0);
    end else begin
      cmp("out_valid", 64'(out_valid), 64'(q.size() > 0));
      cmp("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        h = q[0];
        cmp("regwrite", 64'(RegWrite_out), 64'(h.rw));
        cmp("waw_squash", 64'(waw_squash), 64'(h.waw));
        cmp("memtoreg", 64'(MemToReg_out), 64'(h.mtr));
        cmp("mem_data", 64'(mem_read_data_out), 64'(h.mem));
        cmp("alu_result", 64'(alu_result_out), 64'(h.alu));
        cmp("write_reg", 64'(write_reg_out), 64'(h.wr));
        cmp("wb_data", 64'(wb_data_out), exp_wb(h));
      end else begin
        cmp("idle_regwrite", 64'(RegWrite_out), 64'd0);
        cmp("idle_waw", 64'(waw_squash), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bund(input logic [L-1:0] rw, input logic [L*RW-1:0] wr,
                      input logic [L*DW-1:0] alu, input logic [L*DW-1:0] mem,
                      input logic [L-1:0] mtr, input logic [L-1:0] kill);
    in_valid      = 1'b1;
    RegWrite      = rw;
    write_reg     = wr;
    alu_result    = alu;
    mem_read_data = mem;
    MemToReg      = mtr;
    kill_mask     = kill;
  endtask

  initial begin
    // Reset and idle after release.
    repeat (3) tick();
    cmp("reset_hold_valid", 64'(out_valid), 64'd0);
    reset = 1'b1;
    tick();
    cmp("post_reset_valid", 64'(out_valid), 64'd0);
    cmp("post_reset_ready", 64'(in_ready), 64'd1);

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bund(2'b11, {5'd4, 5'd3}, {32'h20 + 32'(i), 32'h10 + 32'(i)}, 64'h0, 2'b00, 2'b00);
      tick();
      cmp("stream_valid", 64'(out_valid), 64'd1);
      cmp("stream_alu", 64'(alu_result_out[31:0]), 64'h10 + 64'(i));
      cmp("stream_rw", 64'(RegWrite_out), 64'd3);
      cmp("stream_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    cmp("stream_drain", 64'(out_valid), 64'd0);

    // Backpressure: second bundle parks in skid, third is refused.
    bund(2'b11, {5'd4, 5'd3}, {32'h0, 32'h30}, 64'h0, 2'b00, 2'b00);
    tick();
    out_ready = 1'b0;
    bund(2'b11, {5'd4, 5'd3}, {32'h0, 32'h31}, 64'h0, 2'b00, 2'b00);
    tick();
    cmp("bp_hold_alu", 64'(alu_result_out[31:0]), 64'h30);
    cmp("bp_ready_low", 64'(in_ready), 64'd0);
    bund(2'b11, {5'd4, 5'd3}, {32'h0, 32'h32}, 64'h0, 2'b00, 2'b00);
    tick();
    cmp("bp_hold2_alu", 64'(alu_result_out[31:0]), 64'h30);
    tick();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    cmp("bp_release_alu", 64'(alu_result_out[31:0]), 64'h31);
    cmp("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    cmp("bp_empty", 64'(out_valid), 64'd0);

    // Write-after-write and zero register.
    bund(2'b11, {5'd7, 5'd7}, 64'h0, 64'h0, 2'b00, 2'b00);
    tick();
    cmp("waw_rw", 64'(RegWrite_out), 64'h2);
    cmp("waw_squash", 64'(waw_squash), 64'h1);
    bund(2'b11, {5'd5, 5'd0}, 64'h0, 64'h0, 2'b00, 2'b00);
    tick();
    cmp("zero_reg_rw", 64'(RegWrite_out), 64'h2);
    cmp("zero_reg_waw", 64'(waw_squash), 64'h0);

    // Kill plus memory select.
    bund(2'b11, {5'd2, 5'd1}, {32'h2222, 32'h1111}, {32'h0, 32'hDEAD}, 2'b01, 2'b10);
    tick();
    cmp("kill_rw", 64'(RegWrite_out), 64'h1);
    cmp("kill_wb_lane0", 64'(wb_data_out[31:0]), 64'hDEAD);
    cmp("kill_wb_lane1", 64'(wb_data_out[63:32]), 64'h2222);
    in_valid  = 1'b0;
    kill_mask = '0;
    tick();

    // Flush with both entries full and a new input pending.
    out_ready = 1'b0;
    bund(2'b01, {5'd0, 5'd9}, {32'h0, 32'h40}, 64'h0, 2'b00, 2'b00);
    tick();
    bund(2'b01, {5'd0, 5'd9}, {32'h0, 32'h41}, 64'h0, 2'b00, 2'b00);
    tick();
    cmp("flush_pre_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    bund(2'b01, {5'd0, 5'd9}, {32'h0, 32'h42}, 64'h0, 2'b00, 2'b00);
    tick();
    flush = 1'b0;
    cmp("flush_valid", 64'(out_valid), 64'd0);
    cmp("flush_ready", 64'(in_ready), 64'd1);
    cmp("flush_rw", 64'(RegWrite_out), 64'd0);
    out_ready = 1'b1;
    bund(2'b01, {5'd0, 5'd9}, {32'h0, 32'h77}, 64'h0, 2'b00, 2'b00);
    tick();
    cmp("post_flush_valid", 64'(out_valid), 64'd1);
    cmp("post_flush_alu", 64'(alu_result_out[31:0]), 64'h77);

    // Flush discards a bundle offered in the same cycle.
    out_ready = 1'b0;
    flush = 1'b1;
    bund(2'b01, {5'd0, 5'd9}, {32'h0, 32'h88}, 64'h0, 2'b00, 2'b00);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    cmp("flush_incoming", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick();

    // Asynchronous reset between edges clears outputs immediately.
    bund(2'b11, {5'd6, 5'd5}, {32'h55, 32'h44}, {32'h66, 32'h77}, 2'b10, 2'b00);
    tick();
    in_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    cmp("async_rst_valid", 64'(out_valid), 64'd0);
    cmp("async_rst_rw", 64'(RegWrite_out), 64'd0);
    cmp("async_rst_alu", 64'(alu_result_out), 64'd0);
    cmp("async_rst_wb", 64'(wb_data_out), 64'd0);
    cmp("async_rst_wr", 64'(write_reg_out), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      in_valid      = ($urandom % 4) != 0;
      out_ready     = ($urandom % 4) != 0;
      flush         = ($urandom % 32) == 0;
      kill_mask     = L'($urandom);
      MemToReg      = L'($urandom);
      RegWrite      = L'($urandom);
      mem_read_data = {$urandom, $urandom};
      alu_result    = {$urandom, $urandom};
      write_reg     = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
